// File: rtl/orv64_cpu_noc_responder.sv
// Single-outstanding line responder standing in for L2 behind the orv64 store buffer.
// Optional write acknowledge: define ORV64_CPU_NOC_RESP_WRITE_ACK_EN.
package orv64_cpu_noc_pkg;
    localparam int PADDR_W = 40;
    localparam int TID_W   = 8;

    typedef logic [3:0] cpu_req_type_t;

    localparam cpu_req_type_t REQ_READ  = 4'd0;
    localparam cpu_req_type_t REQ_WRITE = 4'd1;

    typedef struct packed {
        logic [PADDR_W-1:0] req_paddr;
        logic [255:0]       req_data;
        logic [31:0]        req_mask;
        logic [TID_W-1:0]   req_tid;
        cpu_req_type_t      req_type;
    } cpu_cache_if_req_t;

    typedef struct packed {
        logic [255:0]     resp_data;
        logic [TID_W-1:0] resp_tid;
    } cpu_cache_if_resp_t;
endpackage

module orv64_cpu_noc_responder
    import orv64_cpu_noc_pkg::*;
#(
    parameter int DEPTH_LINES = 256,
    parameter int LATENCY     = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  cpu_cache_if_req_t  cpu_req,
    input  logic               cpu_req_valid,
    output logic               cpu_req_ready,
    output cpu_cache_if_resp_t cpu_resp,
    output logic               cpu_resp_valid,
    input  logic               cpu_resp_ready,
    output logic               err_req
);
    localparam int IDX_W = $clog2(DEPTH_LINES);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [3:0]         cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic [255:0]       data_q;
    logic [31:0]        mask_q;
    logic [TID_W-1:0]   tid_q;
    cpu_req_type_t      type_q;
    cpu_cache_if_resp_t resp_q;
    logic [255:0]       mem [DEPTH_LINES];

    logic accept;
    logic last;
    logic is_rd;
    logic is_wr;
    logic unused_paddr;

    // Only the index field of the address matters; offset and high bits alias.
    assign unused_paddr = ^cpu_req.req_paddr;

    assign accept = (state_q == IDLE) && cpu_req_valid;
    assign last   = (state_q == ACCESS) && (cnt_q == 4'd0);
    assign is_rd  = (type_q == REQ_READ);
    assign is_wr  = (type_q == REQ_WRITE);

    assign cpu_resp = resp_q;

    always_comb begin
        state_d        = state_q;
        cpu_req_ready  = 1'b0;
        cpu_resp_valid = 1'b0;
        err_req        = 1'b0;
        unique case (state_q)
            IDLE: begin
                cpu_req_ready = 1'b1;
                if (cpu_req_valid) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    unique case (1'b1)
                        is_rd: state_d = RESP;
`ifdef ORV64_CPU_NOC_RESP_WRITE_ACK_EN
                        is_wr: state_d = RESP;
`else
                        is_wr: state_d = IDLE;
`endif
                        default: begin
                            err_req = 1'b1;
                            state_d = IDLE;
                        end
                    endcase
                end
            end
            RESP: begin
                cpu_resp_valid = 1'b1;
                if (cpu_resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q <= 4'(LATENCY - 1);
            end else if (state_q == ACCESS && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (last && is_rd) begin
                resp_q.resp_data <= mem[idx_q];
                resp_q.resp_tid  <= tid_q;
            end
`ifdef ORV64_CPU_NOC_RESP_WRITE_ACK_EN
            if (last && is_wr) begin
                resp_q.resp_data <= '0;
                resp_q.resp_tid  <= tid_q;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q  <= cpu_req.req_paddr[5 +: IDX_W];
            data_q <= cpu_req.req_data;
            mask_q <= cpu_req.req_mask;
            tid_q  <= cpu_req.req_tid;
            type_q <= cpu_req.req_type;
        end
    end

    // Commit is gated by reset so a write interrupted before its last cycle is lost.
    always_ff @(posedge clk) begin
        if (rst_n && last && is_wr) begin
            for (int b = 0; b < 32; b++) begin
                if (mask_q[b]) begin
                    mem[idx_q][8*b +: 8] <= data_q[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_orv64_cpu_noc_responder.sv
// Directed bench for orv64_cpu_noc_responder (LATENCY=2 main, LATENCY=4 reset case).
// Default build: writes are silent, no write acknowledge.
module tb_orv64_cpu_noc_responder;
    import orv64_cpu_noc_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    cpu_cache_if_req_t  req;
    logic               req_valid;
    logic               req_ready;
    cpu_cache_if_resp_t resp;
    logic               resp_valid;
    logic               resp_ready;
    logic               err;

    logic               rst4_n;
    cpu_cache_if_req_t  req4;
    logic               req4_valid;
    logic               req4_ready;
    cpu_cache_if_resp_t resp4;
    logic               resp4_valid;
    logic               resp4_ready;
    logic               err4;

    int total = 0;
    int bad   = 0;
    int err_cnt  = 0;
    int err4_cnt = 0;

    orv64_cpu_noc_responder #(.DEPTH_LINES(256), .LATENCY(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cpu_req(req),
        .cpu_req_valid(req_valid),
        .cpu_req_ready(req_ready),
        .cpu_resp(resp),
        .cpu_resp_valid(resp_valid),
        .cpu_resp_ready(resp_ready),
        .err_req(err)
    );

    orv64_cpu_noc_responder #(.DEPTH_LINES(256), .LATENCY(4)) dut4 (
        .clk(clk),
        .rst_n(rst4_n),
        .cpu_req(req4),
        .cpu_req_valid(req4_valid),
        .cpu_req_ready(req4_ready),
        .cpu_resp(resp4),
        .cpu_resp_valid(resp4_valid),
        .cpu_resp_ready(resp4_ready),
        .err_req(err4)
    );

    always @(negedge clk) begin
        if (err === 1'b1) err_cnt++;
        if (err4 === 1'b1) err4_cnt++;
    end

    function automatic logic [255:0] fill(input logic [7:0] b);
        return {32{b}};
    endfunction

    // Called at a negedge with DUT idle; returns at negedge of ACCESS cycle 1.
    task automatic issue(input logic [3:0] t, input logic [39:0] a,
                         input logic [255:0] d, input logic [31:0] m,
                         input logic [7:0] id);
        req.req_type  = t;
        req.req_paddr = a;
        req.req_data  = d;
        req.req_mask  = m;
        req.req_tid   = id;
        req_valid     = 1'b1;
        @(negedge clk);
        req_valid     = 1'b0;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (req_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic write_line(input logic [39:0] a, input logic [255:0] d,
                              input logic [31:0] m, input logic [7:0] id,
                              output bit ok);
        issue(REQ_WRITE, a, d, m, id);
        wait_ready(ok);
    endtask

    task automatic read_line(input logic [39:0] a, input logic [7:0] id,
                             output logic [255:0] d, output logic [7:0] tid,
                             output bit ok);
        resp_ready = 1'b1;
        issue(REQ_READ, a, '0, '0, id);
        ok = 1'b0;
        d = '0;
        tid = '0;
        for (int i = 0; i < 30; i++) begin
            if (resp_valid === 1'b1) begin
                d = resp.resp_data;
                tid = resp.resp_tid;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rst4_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_hs: ready=%b valid=%b want 1 0", req_ready, resp_valid);
        end
        total++;
        if (resp !== '0) begin
            bad++;
            $display("FAIL reset_resp: got %h want 0", resp);
        end
        rst_n = 1'b1;
        rst4_n = 1'b1;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL post_reset: ready=%b valid=%b err=%b want 1 0 0",
                     req_ready, resp_valid, err);
        end
        repeat (3) @(negedge clk);
        total++;
        if (err_cnt != 0) begin
            bad++;
            $display("FAIL idle_err: got %0d pulses want 0", err_cnt);
        end
    endtask

    task automatic test_write_read;
        logic [255:0] pat;
        logic [7:0]   st [6];
        for (int i = 0; i < 32; i++) pat[8*i +: 8] = 8'(i);
        issue(REQ_WRITE, 40'h40, pat, 32'hFFFF_FFFF, 8'd1);
        st[0] = {7'd0, req_ready};
        @(negedge clk);
        st[1] = {7'd0, req_ready};
        @(negedge clk);
        st[2] = {6'd0, req_ready, resp_valid};
        total++;
        if (st[0] !== 8'd0 || st[1] !== 8'd0 || st[2] !== 8'b10) begin
            bad++;
            $display("FAIL wr_timing: got %h %h %h want 00 00 02", st[0], st[1], st[2]);
        end
        resp_ready = 1'b1;
        issue(REQ_READ, 40'h40, '0, '0, 8'd2);
        st[3] = {7'd0, resp_valid};
        @(negedge clk);
        st[4] = {7'd0, resp_valid};
        @(negedge clk);
        total++;
        if (st[3] !== 8'd0 || st[4] !== 8'd0 || resp_valid !== 1'b1) begin
            bad++;
            $display("FAIL rd_latency: got %h %h %b want 00 00 1", st[3], st[4], resp_valid);
        end
        total++;
        if (resp.resp_data !== pat || resp.resp_tid !== 8'd2) begin
            bad++;
            $display("FAIL rd_data: got %h/%h want %h/02", resp.resp_data, resp.resp_tid, pat);
        end
        @(negedge clk);
        total++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL rd_one_cycle: valid=%b ready=%b want 0 1", resp_valid, req_ready);
        end
    endtask

    task automatic test_partial;
        bit ok1, ok2, ok3;
        logic [255:0] d;
        logic [7:0]   t;
        write_line(40'h80, fill(8'hAA), 32'hFFFF_FFFF, 8'd3, ok1);
        write_line(40'h80, fill(8'h55), 32'h0000_000F, 8'd4, ok2);
        read_line(40'h80, 8'd5, d, t, ok3);
        total++;
        if (!(ok1 && ok2 && ok3)) begin
            bad++;
            $display("FAIL partial_timeout: got %b%b%b want 111", ok1, ok2, ok3);
        end
        total++;
        if (d !== {{28{8'hAA}}, {4{8'h55}}} || t !== 8'd5) begin
            bad++;
            $display("FAIL partial_data: got %h/%h want %h/05", d, t,
                     {{28{8'hAA}}, {4{8'h55}}});
        end
    endtask

    task automatic test_backpressure;
        logic [255:0] pat;
        logic [255:0] d;
        logic [7:0]   t;
        bit ok;
        int stall_bad;
        for (int i = 0; i < 32; i++) pat[8*i +: 8] = 8'(i);
        resp_ready = 1'b0;
        issue(REQ_READ, 40'h40, '0, '0, 8'd3);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (resp_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL bp_timeout: got valid=%b want 1", resp_valid);
        end
        req.req_type  = REQ_WRITE;
        req.req_paddr = 40'hC0;
        req.req_data  = fill(8'h77);
        req.req_mask  = 32'hFFFF_FFFF;
        req.req_tid   = 8'd9;
        req_valid     = 1'b1;
        stall_bad = 0;
        for (int k = 0; k < 5; k++) begin
            if (resp_valid !== 1'b1 || req_ready !== 1'b0 ||
                resp.resp_data !== pat || resp.resp_tid !== 8'd3) stall_bad++;
            @(negedge clk);
        end
        total++;
        if (stall_bad != 0) begin
            bad++;
            $display("FAIL bp_stable: got %0d bad stall cycles want 0", stall_bad);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        total++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: valid=%b ready=%b want 0 1", resp_valid, req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        total++;
        if (req_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_accept: ready=%b want 0", req_ready);
        end
        wait_ready(ok);
        read_line(40'hC0, 8'd6, d, t, ok);
        total++;
        if (!ok || d !== fill(8'h77)) begin
            bad++;
            $display("FAIL bp_held_write: got %h want %h", d, fill(8'h77));
        end
    endtask

    task automatic test_alias_err;
        bit ok1, ok2, ok3;
        logic [255:0] d;
        logic [7:0]   t;
        int e0;
        int vbad;
        write_line(40'h2000, fill(8'h3C), 32'hFFFF_FFFF, 8'd7, ok1);
        read_line(40'h0000, 8'd8, d, t, ok2);
        total++;
        if (!(ok1 && ok2) || d !== fill(8'h3C) || t !== 8'd8) begin
            bad++;
            $display("FAIL alias: got %h/%h want %h/08", d, t, fill(8'h3C));
        end
        e0 = err_cnt;
        vbad = 0;
        issue(4'hF, 40'h0000, fill(8'hEE), 32'hFFFF_FFFF, 8'd10);
        for (int i = 0; i < 6; i++) begin
            if (resp_valid !== 1'b0) vbad++;
            @(negedge clk);
        end
        total++;
        if (err_cnt - e0 != 1) begin
            bad++;
            $display("FAIL err_pulse: got %0d pulses want 1", err_cnt - e0);
        end
        total++;
        if (vbad != 0) begin
            bad++;
            $display("FAIL err_noresp: got %0d valid cycles want 0", vbad);
        end
        read_line(40'h0000, 8'd11, d, t, ok3);
        total++;
        if (!ok3 || d !== fill(8'h3C)) begin
            bad++;
            $display("FAIL err_mem: got %h want %h", d, fill(8'h3C));
        end
    endtask

    task automatic test_reset_mid_access;
        bit ok;
        logic [255:0] d;
        resp4_ready = 1'b1;
        req4.req_type  = REQ_WRITE;
        req4.req_paddr = 40'h100;
        req4.req_data  = fill(8'h11);
        req4.req_mask  = 32'hFFFF_FFFF;
        req4.req_tid   = 8'd1;
        req4_valid     = 1'b1;
        @(negedge clk);
        req4_valid = 1'b0;
        repeat (6) @(negedge clk);
        req4.req_data = fill(8'hFF);
        req4.req_tid  = 8'd2;
        req4_valid    = 1'b1;
        @(negedge clk);
        req4_valid = 1'b0;
        @(negedge clk);
        rst4_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst4_n = 1'b1;
        @(negedge clk);
        total++;
        if (req4_ready !== 1'b1 || resp4_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_rst_state: ready=%b valid=%b want 1 0", req4_ready, resp4_valid);
        end
        req4.req_type = REQ_READ;
        req4.req_tid  = 8'd3;
        req4_valid    = 1'b1;
        @(negedge clk);
        req4_valid = 1'b0;
        ok = 1'b0;
        d = '0;
        for (int i = 0; i < 30; i++) begin
            if (resp4_valid === 1'b1) begin
                d = resp4.resp_data;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!ok || d !== fill(8'h11)) begin
            bad++;
            $display("FAIL mid_rst_data: got %h want %h", d, fill(8'h11));
        end
        total++;
        if (err4_cnt != 0) begin
            bad++;
            $display("FAIL mid_rst_err: got %0d want 0", err4_cnt);
        end
    endtask

    initial begin
        req = '0;
        req_valid = 1'b0;
        resp_ready = 1'b1;
        req4 = '0;
        req4_valid = 1'b0;
        resp4_ready = 1'b1;
        rst_n = 1'b0;
        rst4_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_partial();
        test_backpressure();
        test_alias_err();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/orv64_cpu_noc_responder.md
# orv64_cpu_noc_responder

Responder end of the orv64 CPU-cache request interface: accepts `cpu_cache_if_req_t` line requests (as issued by the orv64 store buffer toward L2), services them from a local line-wide SRAM array, and returns `cpu_cache_if_resp_t` read responses. It stands in for the L2 in core-level integration and FPGA bring-up. It handles one outstanding request at a time, with fixed configurable access latency and full valid/ready handshakes on both channels.

## Interface
Parameters:
- `DEPTH_LINES`, default 256: number of 32-byte lines in the array; must be a power of two, at least 2.
- `LATENCY`, default 2: number of ACCESS cycles per request; legal range 1..15.

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst_n`  in  1  reset; synchronous, active-low.
- `cpu_req`  in  `cpu_cache_if_req_t`  request: `req_paddr`, `req_data` (256b), `req_mask` (32b, one bit per byte), `req_tid`, `req_type`.
- `cpu_req_valid`  in  1  request valid.
- `cpu_req_ready`  out  1  request accepted when high together with `cpu_req_valid`.
- `cpu_resp`  out  `cpu_cache_if_resp_t`  response: `resp_data` (256b), `resp_tid`.
- `cpu_resp_valid`  out  1  response valid.
- `cpu_resp_ready`  in  1  response consumed when high together with `cpu_resp_valid`.
- `err_req`  out  1  one-cycle pulse when an unsupported `req_type` is retired.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE:
  - `cpu_req_ready`=1.
  - On `cpu_req_valid`: latch `req_paddr`, `req_data`, `req_mask`, `req_tid` and `req_type`; load the down-counter with `LATENCY-1`; go to ACCESS.
- ACCESS:
  - `cpu_req_ready`=0; the counter decrements each cycle.
  - Last cycle is when the counter equals 0.
  - REQ_WRITE on the last cycle: for each byte b in 0..31 with `req_mask[b]`=1, write `req_data[8b+:8]` into the line. Bytes with a clear mask bit keep their old value. An all-zero mask leaves the line unchanged.
  - REQ_READ on the last cycle: capture the full line into the response register; go to RESP.
  - Any other type: no array access; pulse `err_req`; go to IDLE.
  - Writes go to IDLE after the last cycle; see Configuration.
- RESP:
  - `cpu_resp_valid`=1; `resp_data` and `resp_tid` (echoed `req_tid`) are held stable.
  - On `cpu_resp_ready`=1, go to IDLE.
- Line index is `req_paddr[5 +: $clog2(DEPTH_LINES)]`. Offset bits [4:0] are ignored. Address bits above the index alias (wrap modulo `DEPTH_LINES`).
- Array contents are not cleared by reset; reading an unwritten line returns undefined data.
- Read-after-write ordering is guaranteed: a write commits before `cpu_req_ready` returns high.

## Timing
- Reset values: state=IDLE, `cpu_req_ready`=1, `cpu_resp_valid`=0, `err_req`=0, `cpu_resp` fields=0.
- Accept at edge t0. ACCESS occupies cycles t0+1 .. t0+LATENCY. `cpu_resp_valid` first rises in cycle t0+LATENCY+1.
- Write: `cpu_req_ready` returns high in cycle t0+LATENCY+1.
- Read with `cpu_resp_ready` held high: `cpu_resp_valid` is high for exactly one cycle, and `cpu_req_ready` returns high the following cycle.
- Minimum occupancy: `LATENCY`+1 cycles per write and `LATENCY`+2 per read when unstalled. Back-to-back requests never overlap.
- `cpu_req_valid` while not ready is ignored and not latched; the requester must hold it.
- Reset mid-ACCESS: the pending write is discarded if its commit cycle has not yet occurred.
- Reset mid-RESP: `cpu_resp_valid` drops in the next cycle.

## Configuration
- `ORV64_CPU_NOC_RESP_WRITE_ACK_EN`
  - Defined: REQ_WRITE also goes to RESP after commit and returns a response with `resp_data`=0 and `resp_tid`=`req_tid`. Write occupancy then matches read occupancy.
  - Undefined: writes retire silently to IDLE and `cpu_resp_valid` is asserted only for reads. This matches the store buffer, which flags a response without a pending read.

## Test plan
- Reset, then idle: `cpu_req_ready`=1 and `cpu_resp_valid`=0 during reset and the first cycle after it; `err_req` never pulses.
- Full-mask write then read: LATENCY=2. Write paddr 0x40, data 0x1F1E…0100, mask 0xFFFFFFFF, tid 1. Then read 0x40, tid 2, `cpu_resp_ready`=1. Response rises 3 cycles after read accept with data 0x1F1E…0100 and tid 2.
- Partial mask: write all-0xAA to line 0x80, then write all-0x55 with mask 0x0000000F. Read 0x80 returns bytes 0–3=0x55 and bytes 4–31=0xAA.
- Backpressure: read with `cpu_resp_ready`=0 for 5 cycles. `cpu_resp_valid` and data stay stable, `cpu_req_ready`=0 throughout, and a new request is accepted the cycle after the ready handshake.
- Aliasing and unsupported type: with DEPTH_LINES=256, a write to 0x2000 is read back at 0x0000. An unsupported `req_type` pulses `err_req` once, produces no response, and leaves memory unchanged.
- Reset mid-ACCESS with LATENCY=4: write 0xFF bytes to line 0x100, assert `rst_n`=0 in ACCESS cycle 2. Line 0x100 retains its prior value.
